seg_view_ctrl: RTL and testbench
================================

SEG_VIEW_CTRL -- requirements
Module: seg_view_ctrl

Interface
REQ-001 Parameter NUM_VIEWS, default 4, number of selectable 32-bit views (legal 2..8).
REQ-002 Parameter NUM_DIGITS, default 8, number of scanned hex digits (legal 4..8).
REQ-003 Parameter SCAN_INTERVAL, default 49999, cycles per digit dwell minus one.
REQ-004 Parameter ROTATE_INTERVAL, default 99_999_999, cycles per auto-rotate step minus one.
REQ-005 i_clk  in  1  single clock; every flop is clocked on its rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_view_data  in  NUM_VIEWS*4*NUM_DIGITS  packed view data; view k occupies slice k.
REQ-008 i_view_valid  in  NUM_VIEWS  bit k set = view k selectable.
REQ-009 i_mode  in  1  0 = MANUAL, 1 = AUTO.
REQ-010 i_next  in  1  level from a debounced button; a rising edge requests the next view.
REQ-011 i_peek  in  NUM_VIEWS  press-and-hold override; bit k held = show view k.
REQ-012 i_freeze  in  1  holds the displayed value.
REQ-013 o_view_idx  out  3  index of the view currently shown.
REQ-014 o_blank  out  1  high when no view is shown.
REQ-015 o_seg_valid  out  NUM_DIGITS  active-low one-hot digit enable.
REQ-016 o_seg_value  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always off.

Function
REQ-017 The selector FSM SHALL have two states, SHOW and PEEK, and SHALL reset to SHOW.
REQ-018 SHOW->PEEK SHALL occur when any i_peek bit is high; PEEK->SHOW SHALL occur when all i_peek bits are low.
REQ-019 In PEEK, the shown view SHALL be the lowest set i_peek index, regardless of i_view_valid; cur_view SHALL be unchanged.
REQ-020 In SHOW, the shown view SHALL be cur_view.
REQ-021 In SHOW with MANUAL mode, an i_next rising edge SHALL advance cur_view to the next higher valid index, wrapping NUM_VIEWS-1 -> 0.
REQ-022 In SHOW with AUTO mode, the rotate counter SHALL advance cur_view (same rule as REQ-021) when it reaches ROTATE_INTERVAL, then restart at 0; i_next edges SHALL also advance it.
REQ-023 The rotate counter SHALL clear on every cur_view change, on a mode change, and while in PEEK.
REQ-024 In SHOW, if cur_view becomes invalid, the block SHALL advance cur_view to the next valid view on the following cycle.
REQ-025 If no view is valid in SHOW, o_blank SHALL be 1, cur_view SHALL hold, and all o_seg_valid bits SHALL be 1.
REQ-026 An i_next edge or rotate tick coinciding with a PEEK entry SHALL be discarded.
REQ-027 If only cur_view is valid, an advance request SHALL leave cur_view unchanged.
REQ-028 The display shadow register SHALL load the shown view's slice one cycle after selection, and SHALL hold while i_freeze=1.
REQ-029 o_view_idx SHALL update in the same cycle the shadow register loads.
REQ-030 The digit scanner SHALL step digit 0 -> NUM_DIGITS-1 -> 0 every SCAN_INTERVAL+1 cycles.
REQ-031 Digit d SHALL display shadow nibble [4d+3:4d] decoded to hex glyphs 0-F.

Reset
REQ-032 Reset SHALL set: cur_view=0, state=SHOW, all counters=0, shadow=0, o_view_idx=0, o_blank=1, o_seg_valid=all-ones, o_seg_value=8'hFF.
REQ-033 The i_next edge-detect register SHALL reset to 1, so a button held through reset does not advance.
REQ-034 Reset asserted mid-scan or mid-PEEK SHALL take effect on the next clock edge, with no residual state.

Structure
REQ-035 Package seg_pkg SHALL hold the SHOW/PEEK state encoding, the MANUAL/AUTO mode constants, and the 16-entry hex-to-segment table.
REQ-036 Sub-module seg_scan SHALL hold the scan counter, the digit rotation and the glyph decode; it is parametrised by NUM_DIGITS and SCAN_INTERVAL.

Verification (NUM_VIEWS=4, NUM_DIGITS=8, SCAN_INTERVAL=3, ROTATE_INTERVAL=15)
REQ-037 Valid=4'b1011, MANUAL, four i_next pulses starting at view 0 -> o_view_idx sequence 1,3,0,1.
REQ-038 AUTO, valid=4'b1111, no input -> o_view_idx increments every 16 cycles and wraps 3->0.
REQ-039 Showing view 1, i_peek=4'b1100 held 20 cycles then released -> idx=2 during the hold, returns to 1, and the rotate counter restarts.
REQ-040 View 0 data=32'h12345678, i_freeze asserted, data changed to 32'hDEADBEEF -> digit 0 glyph stays "8" (8'h80) until i_freeze drops.
REQ-041 Valid drops to 4'b0000 -> o_blank=1 and o_seg_valid=8'hFF; restore valid=4'b0100 -> idx=2 within 2 cycles.
REQ-042 Assert i_rst mid-scan while in PEEK -> all outputs reach the REQ-032 values one edge later.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the segment view controller.
//   sel_state_t  : selector FSM encoding (SHOW / PEEK)
//   MODE_*       : values of i_mode
//   HEX_GLYPH    : nibble -> active-low {dp,g,f,e,d,c,b,a}, dp held off
package seg_pkg;

   typedef enum logic {
      ST_SHOW = 1'b0,
      ST_PEEK = 1'b1
   } sel_state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   // Index 0 first: glyphs 0..9, A, b, C, d, E, F.
   localparam logic [7:0] HEX_GLYPH [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

endpackage

// File: rtl/seg_scan.sv
// seg_scan: multiplexed hex-digit scanner.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_shadow       : 4*NUM_DIGITS bits, digit d shows nibble [4d+3:4d]
//   i_blank        : forces every digit enable and segment off
//   o_seg_valid    : active-low one-hot digit enable
//   o_seg_value    : active-low segments {dp,g,f,e,d,c,b,a}
module seg_scan
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int SCAN_INTERVAL = 49999
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [4*NUM_DIGITS-1:0] i_shadow,
   input  logic                    i_blank,
   output logic [NUM_DIGITS-1:0]   o_seg_valid,
   output logic [7:0]              o_seg_value
);

   localparam int SCAN_W = (SCAN_INTERVAL > 0) ? $clog2(SCAN_INTERVAL + 1) : 1;

   logic [SCAN_W-1:0] scan_cnt_reg;
   logic [2:0]        digit_reg;
   logic [3:0]        nibble [8];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         scan_cnt_reg <= '0;
         digit_reg    <= '0;
      end else if (scan_cnt_reg == SCAN_W'(SCAN_INTERVAL)) begin
         scan_cnt_reg <= '0;
         digit_reg    <= (digit_reg == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_reg + 3'd1;
      end else begin
         scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end
   end

   // Nibble table is padded to 8 entries so the 3-bit digit index always fits.
   for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
      if (gi < NUM_DIGITS) begin : g_used
         assign nibble[gi] = i_shadow[4*gi +: 4];
      end else begin : g_pad
         assign nibble[gi] = 4'h0;
      end
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_enable
      assign o_seg_valid[gi] = i_blank | (digit_reg != 3'(gi));
   end

   assign o_seg_value = i_blank ? 8'hFF : HEX_GLYPH[nibble[digit_reg]];

endmodule

// File: rtl/seg_view_ctrl.sv
// seg_view_ctrl: selects one of NUM_VIEWS 32-bit views for a scanned hex display.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_view_data   : packed views, view k in slice k
//   i_view_valid  : bit k set = view k may be selected
//   i_mode        : 0 manual stepping, 1 auto rotation
//   i_next        : debounced button level, rising edge steps to next view
//   i_peek        : held bit k shows view k (lowest set bit wins)
//   i_freeze      : holds the displayed value and index
//   o_view_idx    : index of the view on the display
//   o_blank       : display dark because nothing is selectable
//   o_seg_valid   : active-low one-hot digit enable
//   o_seg_value   : active-low segments {dp,g,f,e,d,c,b,a}
module seg_view_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_VIEWS       = 4,
   parameter int NUM_DIGITS      = 8,
   parameter int SCAN_INTERVAL   = 49999,
   parameter int ROTATE_INTERVAL = 99_999_999
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [NUM_VIEWS*4*NUM_DIGITS-1:0] i_view_data,
   input  logic [NUM_VIEWS-1:0]              i_view_valid,
   input  logic                              i_mode,
   input  logic                              i_next,
   input  logic [NUM_VIEWS-1:0]              i_peek,
   input  logic                              i_freeze,
   output logic [2:0]                        o_view_idx,
   output logic                              o_blank,
   output logic [NUM_DIGITS-1:0]             o_seg_valid,
   output logic [7:0]                        o_seg_value
);

   localparam int VW    = 4 * NUM_DIGITS;
   localparam int ROT_W = (ROTATE_INTERVAL > 0) ? $clog2(ROTATE_INTERVAL + 1) : 1;

   sel_state_t       state_reg, state_next;
   logic [2:0]       cur_view_reg, cur_view_next;
   logic [ROT_W-1:0] rot_cnt_reg, rot_cnt_next;
   logic             next_d_reg;
   logic             mode_d_reg;
   logic [VW-1:0]    shadow_reg;
   logic [2:0]       view_idx_reg;
   logic             blank_reg;

   // Views, valid and peek bits padded to 8 entries for 3-bit indexing.
   logic [VW-1:0] view_slice [8];
   logic [7:0]    valid_ext;
   logic [7:0]    peek_ext;

   for (genvar gi = 0; gi < 8; gi++) begin : g_ext
      if (gi < NUM_VIEWS) begin : g_used
         assign view_slice[gi] = i_view_data[gi*VW +: VW];
         assign valid_ext[gi]  = i_view_valid[gi];
         assign peek_ext[gi]   = i_peek[gi];
      end else begin : g_pad
         assign view_slice[gi] = '0;
         assign valid_ext[gi]  = 1'b0;
         assign peek_ext[gi]   = 1'b0;
      end
   end

   logic       peek_any, any_valid, next_rise, rot_tick, adv_found;
   logic [2:0] peek_idx, adv_idx, shown_idx;
   logic [3:0] cand;
   logic       shown_blank;

   always_comb begin
      peek_any  = |i_peek;
      any_valid = |i_view_valid;
      next_rise = i_next & ~next_d_reg;
      rot_tick  = (i_mode == MODE_AUTO) && (rot_cnt_reg == ROT_W'(ROTATE_INTERVAL));

      // Descending scan so the lowest set peek bit is the one kept.
      peek_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (peek_ext[i]) peek_idx = 3'(i);
      end

      // First valid view above cur_view, wrapping; the final candidate is
      // cur_view itself, so a lone valid view stays put.
      adv_idx   = cur_view_reg;
      adv_found = 1'b0;
      cand      = 4'd0;
      for (int i = 1; i <= NUM_VIEWS; i++) begin
         cand = {1'b0, cur_view_reg} + 4'(i);
         if (cand >= 4'(NUM_VIEWS)) cand = cand - 4'(NUM_VIEWS);
         if (!adv_found && valid_ext[cand[2:0]]) begin
            adv_idx   = cand[2:0];
            adv_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      cur_view_next = cur_view_reg;
      rot_cnt_next  = rot_cnt_reg;

      if (state_reg == ST_SHOW) begin
         if (peek_any) begin
            // Entering PEEK swallows any coincident step request.
            state_next   = ST_PEEK;
            rot_cnt_next = '0;
         end else begin
            if ((!valid_ext[cur_view_reg] || next_rise || rot_tick) && any_valid)
               cur_view_next = adv_idx;
            if ((i_mode != mode_d_reg) || (cur_view_next != cur_view_reg) ||
                rot_tick || (i_mode == MODE_MANUAL))
               rot_cnt_next = '0;
            else
               rot_cnt_next = rot_cnt_reg + 1'b1;
         end
      end else begin
         rot_cnt_next = '0;
         if (!peek_any) state_next = ST_SHOW;
      end
   end

   // In the exit cycle from PEEK the peek bits are already low, so fall
   // back to cur_view rather than showing view 0.
   always_comb begin
      if ((state_reg == ST_PEEK) && peek_any) begin
         shown_idx   = peek_idx;
         shown_blank = 1'b0;
      end else begin
         shown_idx   = cur_view_reg;
         shown_blank = ~any_valid;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg    <= ST_SHOW;
         cur_view_reg <= '0;
         rot_cnt_reg  <= '0;
         next_d_reg   <= 1'b1;
         mode_d_reg   <= MODE_MANUAL;
         shadow_reg   <= '0;
         view_idx_reg <= '0;
         blank_reg    <= 1'b1;
      end else begin
         state_reg    <= state_next;
         cur_view_reg <= cur_view_next;
         rot_cnt_reg  <= rot_cnt_next;
         next_d_reg   <= i_next;
         mode_d_reg   <= i_mode;
         blank_reg    <= shown_blank;
         if (!i_freeze) begin
            shadow_reg   <= view_slice[shown_idx];
            view_idx_reg <= shown_idx;
         end
      end
   end

   assign o_view_idx = view_idx_reg;
   assign o_blank    = blank_reg;

   seg_scan #(
      .NUM_DIGITS    (NUM_DIGITS),
      .SCAN_INTERVAL (SCAN_INTERVAL)
   ) u_scan (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_shadow    (shadow_reg),
      .i_blank     (blank_reg),
      .o_seg_valid (o_seg_valid),
      .o_seg_value (o_seg_value)
   );

endmodule

// File: tb/tb_seg_view_ctrl.sv
module tb_seg_view_ctrl;

   localparam logic [31:0] V0 = 32'h12345678;
   localparam logic [31:0] V1 = 32'h09ABCDEF;
   localparam logic [31:0] V2 = 32'h22222222;
   localparam logic [31:0] V3 = 32'h33333333;

   // Hand-derived active-low glyphs for 0..F, dp off.
   localparam logic [7:0] GLYPH_EXP [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] view_data;
   logic [3:0]   view_valid;
   logic         mode;
   logic         nxt;
   logic [3:0]   peek;
   logic         freeze;
   logic [2:0]   view_idx;
   logic         blank;
   logic [7:0]   seg_valid;
   logic [7:0]   seg_value;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg_view_ctrl #(
      .NUM_VIEWS       (4),
      .NUM_DIGITS      (8),
      .SCAN_INTERVAL   (3),
      .ROTATE_INTERVAL (15)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_view_data  (view_data),
      .i_view_valid (view_valid),
      .i_mode       (mode),
      .i_next       (nxt),
      .i_peek       (peek),
      .i_freeze     (freeze),
      .o_view_idx   (view_idx),
      .o_blank      (blank),
      .o_seg_valid  (seg_valid),
      .o_seg_value  (seg_value)
   );

   typedef struct {
      logic [3:0] valid;
      logic       mode;
      logic       pulse;
      logic [3:0] peek;
      int         waitc;
      logic [2:0] exp_idx;
      logic       exp_blank;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Waits for digit d to become active and returns its segment pattern.
   task automatic capture(input int d, output logic [7:0] g);
      logic [7:0] tgt;
      int k;
      tgt = ~(8'b1 << d);
      g = 8'h00;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (seg_valid == tgt) break;
      end
      if (k == 40) begin
         n_cmp++;
         n_err++;
         $display("FAIL capture_dig%0d: timeout, seg_valid %0h expected %0h", d, seg_valid, tgt);
      end
      g = seg_value;
   endtask

   task automatic check_view_glyphs(input string tag, input logic [31:0] data);
      logic [7:0] g;
      for (int d = 0; d < 8; d++) begin
         capture(d, g);
         check($sformatf("%s_dig%0d", tag, d), 32'(g), 32'(GLYPH_EXP[data[4*d +: 4]]));
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: time %0t expected finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] g;
      int k;
      logic [2:0] exp_seq [4];

      vecs[0]  = '{4'b1011, 1'b0, 1'b0, 4'b0000, 3, 3'd0, 1'b0};
      vecs[1]  = '{4'b1011, 1'b0, 1'b1, 4'b0000, 3, 3'd1, 1'b0};
      vecs[2]  = '{4'b1011, 1'b0, 1'b1, 4'b0000, 3, 3'd3, 1'b0};
      vecs[3]  = '{4'b1011, 1'b0, 1'b1, 4'b0000, 3, 3'd0, 1'b0};
      vecs[4]  = '{4'b1011, 1'b0, 1'b1, 4'b0000, 3, 3'd1, 1'b0};
      vecs[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 3, 3'd1, 1'b1};
      vecs[6]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2, 3'd2, 1'b0};
      vecs[7]  = '{4'b0100, 1'b0, 1'b1, 4'b0000, 3, 3'd2, 1'b0};
      vecs[8]  = '{4'b0100, 1'b0, 1'b0, 4'b0011, 3, 3'd0, 1'b0};
      vecs[9]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 3, 3'd2, 1'b0};
      vecs[10] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 3, 3'd3, 1'b0};
      vecs[11] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 3, 3'd0, 1'b0};
      vecs[12] = '{4'b1111, 1'b0, 1'b1, 4'b1000, 3, 3'd3, 1'b0};
      vecs[13] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 3, 3'd0, 1'b0};

      rst        = 1'b1;
      view_data  = {V3, V2, V1, V0};
      view_valid = 4'b1011;
      mode       = 1'b0;
      nxt        = 1'b0;
      peek       = 4'b0000;
      freeze     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_idx", 32'(view_idx), 32'd0);
      check("rst_blank", 32'(blank), 32'd1);
      check("rst_seg_valid", 32'(seg_valid), 32'hFF);
      check("rst_seg_value", 32'(seg_value), 32'hFF);
      rst = 1'b0;

      // Table: selection, validity, peek and blanking.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         view_valid = vecs[i].valid;
         mode       = vecs[i].mode;
         peek       = vecs[i].peek;
         nxt        = vecs[i].pulse;
         @(negedge clk);
         nxt = 1'b0;
         repeat (vecs[i].waitc - 1) @(negedge clk);
         check($sformatf("vec%0d_idx", i), 32'(view_idx), 32'(vecs[i].exp_idx));
         check($sformatf("vec%0d_blank", i), 32'(blank), 32'(vecs[i].exp_blank));
         if (vecs[i].exp_blank) begin
            check($sformatf("vec%0d_seg_valid", i), 32'(seg_valid), 32'hFF);
            check($sformatf("vec%0d_seg_value", i), 32'(seg_value), 32'hFF);
         end
      end

      // Glyphs of view 0 on every digit, then digit dwell length.
      check_view_glyphs("v0", V0);
      k = 0;
      while (seg_valid == 8'hFE && k < 40) begin @(negedge clk); k++; end
      while (seg_valid != 8'hFE && k < 80) begin @(negedge clk); k++; end
      k = 0;
      while (seg_valid == 8'hFE && k < 20) begin @(negedge clk); k++; end
      check("dwell_cycles", 32'(k), 32'd4);
      check("dwell_next_digit", 32'(seg_valid), 32'hFD);

      // Step to view 1 and check its glyphs (covers 0, 9..F).
      @(negedge clk); nxt = 1'b1;
      @(negedge clk); nxt = 1'b0;
      repeat (2) @(negedge clk);
      check("step_v1_idx", 32'(view_idx), 32'd1);
      check_view_glyphs("v1", V1);

      // Auto rotation: first step 18 cycles after switching mode, then every 16.
      exp_seq[0] = 3'd2; exp_seq[1] = 3'd3; exp_seq[2] = 3'd0; exp_seq[3] = 3'd1;
      @(negedge clk);
      mode = 1'b1;
      for (int s = 0; s < 4; s++) begin
         g = 8'(view_idx);
         for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (8'(view_idx) != g) break;
         end
         check($sformatf("auto%0d_cycles", s), 32'(k), (s == 0) ? 32'd18 : 32'd16);
         check($sformatf("auto%0d_idx", s), 32'(view_idx), 32'(exp_seq[s]));
      end

      // Peek view 2 for 20 cycles while showing view 1; rotation restarts after.
      peek = 4'b1100;
      repeat (2) @(negedge clk);
      check("peek_idx_early", 32'(view_idx), 32'd2);
      repeat (18) @(negedge clk);
      check("peek_idx_late", 32'(view_idx), 32'd2);
      peek = 4'b0000;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) check("peek_return_idx", 32'(view_idx), 32'd1);
         if (k > 1 && view_idx != 3'd1) break;
      end
      check("peek_rotate_restart_cycles", 32'(k), 32'd18);
      check("peek_rotate_restart_idx", 32'(view_idx), 32'd2);

      // Freeze holds the glyphs while the source data changes.
      mode = 1'b0;
      view_data = {4{32'h12345678}};
      repeat (3) @(negedge clk);
      capture(0, g);
      check("prefreeze_dig0", 32'(g), 32'h80);
      freeze = 1'b1;
      @(negedge clk);
      view_data = {4{32'hDEADBEEF}};
      repeat (3) @(negedge clk);
      capture(0, g);
      check("freeze_dig0", 32'(g), 32'h80);
      capture(7, g);
      check("freeze_dig7", 32'(g), 32'hF9);
      freeze = 1'b0;
      repeat (2) @(negedge clk);
      capture(0, g);
      check("unfreeze_dig0", 32'(g), 32'h8E);
      capture(7, g);
      check("unfreeze_dig7", 32'(g), 32'hA1);

      // Reset during PEEK mid-scan, with the button held across reset.
      peek = 4'b0100;
      nxt  = 1'b1;
      repeat (5) @(negedge clk);
      check("pre_rst_peek_idx", 32'(view_idx), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_idx", 32'(view_idx), 32'd0);
      check("midrst_blank", 32'(blank), 32'd1);
      check("midrst_seg_valid", 32'(seg_valid), 32'hFF);
      check("midrst_seg_value", 32'(seg_value), 32'hFF);
      rst  = 1'b0;
      peek = 4'b0000;
      repeat (6) @(negedge clk);
      check("post_rst_held_next_idx", 32'(view_idx), 32'd0);
      check("post_rst_blank", 32'(blank), 32'd0);
      nxt = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
